// File: rtl/idm_pkg.sv
// Shared types and helpers for the unified instruction/data memory controller.
package idm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  // The last byte address is computed one bit wider than any address so it can never wrap.
  function automatic logic out_of_range(input logic [31:0] addr, input int nbytes, input int depth);
    logic [32:0] last;
    last = {1'b0, addr} + 33'(nbytes) - 33'd1;
    return (last >= 33'(depth));
  endfunction

endpackage

// File: rtl/instr_data_mem_ctrl_if.sv
// Request/response bus between the CPU control FSM (master) and the memory controller (slave).
interface instr_data_mem_ctrl_if
  import idm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  localparam int BYTES = bytes_of(DATA_W);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, busy);
endinterface

// File: rtl/idm_byte_array.sv
// DEPTH x 8 byte storage with one write lane and one combinational read lane per word byte.
// Contents are deliberately not reset.
module idm_byte_array #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int BYTES  = 2
) (
  input  logic                 clk,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [BYTES-1:0]     i_we,
  input  logic [8*BYTES-1:0]   i_wdata,
  output logic [8*BYTES-1:0]   o_rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W:0]   w_idx [BYTES];
  logic [IDX_W-1:0]  w_sel [BYTES];
  logic [BYTES-1:0]  w_ok;

  for (genvar g = 0; g < BYTES; g++) begin : g_lane
    assign w_idx[g] = {1'b0, i_addr} + (ADDR_W+1)'(g);
    assign w_sel[g] = w_idx[g][IDX_W-1:0];
    assign w_ok[g]  = (w_idx[g] < (ADDR_W+1)'(DEPTH));
    assign o_rdata[8*g +: 8] = w_ok[g] ? r_mem[w_sel[g]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (i_we[i] && w_ok[i]) begin
        r_mem[w_sel[i]] <= i_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/instr_data_mem_ctrl.sv
// Handshaked byte-addressed memory controller with programmable wait states and range errors.
// Optional build macro MISALIGN_TRAP_EN turns unaligned accesses into errors.
module instr_data_mem_ctrl
  import idm_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_data_mem_ctrl_if.slave  bus
);
  localparam int BYTES = bytes_of(DATA_W);
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, r_bad;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [BYTES-1:0]  r_be, w_we_lane;
  logic              r_ready, r_err, r_busy;
  logic              w_accept, w_bad_in, w_bad_now;
  logic [DATA_W-1:0] w_rd;

  always_comb begin
    w_bad_in = out_of_range(32'(bus.addr), BYTES, DEPTH);
`ifdef MISALIGN_TRAP_EN
    w_bad_in = w_bad_in | ((32'(bus.addr) % 32'(BYTES)) != 32'd0);
`endif
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_cnt_next = CNT_W'(WAIT_CYCLES);
          w_next     = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_next     = RESP;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && bus.req;
  // With zero wait states the error must be known on the acceptance edge itself.
  assign w_bad_now = (r_state == IDLE) ? w_bad_in : r_bad;
  assign w_we_lane = (r_state == RESP && r_we && !r_bad) ? r_be : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
      r_bad   <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr  <= bus.addr;
        r_we    <= bus.we;
        r_wdata <= bus.wdata;
        r_be    <= bus.be;
        r_bad   <= w_bad_in;
      end
      r_ready <= (w_next == RESP);
      r_err   <= (w_next == RESP) && w_bad_now;
      r_busy  <= (w_next != IDLE);
      if (r_state == RESP && !r_we && !r_bad) begin
        r_rdata <= w_rd;
      end
    end
  end

  idm_byte_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BYTES  (BYTES)
  ) u_arr (
    .clk     (clk),
    .i_addr  (r_addr),
    .i_we    (w_we_lane),
    .i_wdata (r_wdata),
    .o_rdata (w_rd)
  );

  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_instr_data_mem_ctrl.sv
// Directed bench for instr_data_mem_ctrl with WAIT_CYCLES = 1, 0 and 3 instances.
`define CHK(TAG, OBS, EXP) \
  begin \
    n_cmp++; \
    assert ((OBS) === (EXP)) else begin \
      n_mis++; \
      $error("FAIL %s: observed %0h, required %0h", TAG, OBS, EXP); \
    end \
  end

module tb_instr_data_mem_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef MISALIGN_TRAP_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(16)) if1 ();
  instr_data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(16)) if0 ();
  instr_data_mem_ctrl_if #(.ADDR_W(8), .DATA_W(16)) if3 ();

  instr_data_mem_ctrl #(.WAIT_CYCLES(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  instr_data_mem_ctrl #(.WAIT_CYCLES(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  instr_data_mem_ctrl #(.WAIT_CYCLES(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

  // One WAIT_CYCLES=1 transaction; inputs are scrambled after acceptance to prove latching.
  task automatic txn1(input logic we, input logic [7:0] a, input logic [15:0] d,
                      input logic [1:0] b, input logic exp_err, input string tag);
    if1.req = 1'b1; if1.we = we; if1.addr = a; if1.wdata = d; if1.be = b;
    @(negedge clk);
    if1.req = 1'b0; if1.we = ~we; if1.addr = 8'hFF; if1.wdata = 16'h0000; if1.be = 2'b00;
    `CHK({tag, "/busy_wait"}, if1.busy, 1'b1)
    `CHK({tag, "/ready_early"}, if1.ready, 1'b0)
    @(negedge clk);
    `CHK({tag, "/ready"}, if1.ready, 1'b1)
    `CHK({tag, "/err"}, if1.err, exp_err)
    @(negedge clk);
    `CHK({tag, "/ready_off"}, if1.ready, 1'b0)
    `CHK({tag, "/busy_off"}, if1.busy, 1'b0)
  endtask

  // One WAIT_CYCLES=3 transaction with a bounded wait; returns the observed latency.
  task automatic txn3(input logic we, input logic [7:0] a, input logic [15:0] d,
                      input logic [1:0] b, output int lat);
    lat = 0;
    if3.req = 1'b1; if3.we = we; if3.addr = a; if3.wdata = d; if3.be = b;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if3.req = 1'b0;
      if (if3.ready && lat == 0) lat = i;
    end
    n_cmp++;
    if (lat == 0) begin
      n_mis++;
      $error("FAIL txn3/timeout: no ready within 8 cycles of request");
    end
  endtask

  logic [9:0] rb0, bb0, rb3, bb3;
  int         lat;
  logic       seen;

  initial begin
    reset = 1'b1;
    if1.req = 1'b0; if1.we = 1'b0; if1.addr = 8'h00; if1.wdata = 16'h0000; if1.be = 2'b00;
    if0.req = 1'b0; if0.we = 1'b0; if0.addr = 8'h00; if0.wdata = 16'h0000; if0.be = 2'b00;
    if3.req = 1'b0; if3.we = 1'b0; if3.addr = 8'h00; if3.wdata = 16'h0000; if3.be = 2'b00;
    repeat (2) @(negedge clk);
    `CHK("rst/rdata", if1.rdata, 16'h0000)
    `CHK("rst/ready", if1.ready, 1'b0)
    `CHK("rst/err", if1.err, 1'b0)
    `CHK("rst/busy", if1.busy, 1'b0)
    `CHK("rst/busy0", if0.busy, 1'b0)
    `CHK("rst/busy3", if3.busy, 1'b0)
    n_cmp++;
    if ({if0.rdata, if0.ready, if0.err, if0.busy,
         if3.rdata, if3.ready, if3.err, if3.busy} !== 38'd0) begin
        n_mis++;
        $error("FAIL rst/all: W=0/W=3 outputs not zero under reset");
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic write/read and byte enables
    txn1(1'b1, 8'h04, 16'hBEEF, 2'b11, 1'b0, "wr04");
    `CHK("wr04/rdata_held", if1.rdata, 16'h0000)
    txn1(1'b0, 8'h04, 16'h0000, 2'b00, 1'b0, "rd04");
    `CHK("rd04/rdata", if1.rdata, 16'hBEEF)
    txn1(1'b1, 8'h04, 16'h1234, 2'b01, 1'b0, "wr04_be01");
    txn1(1'b0, 8'h04, 16'h0000, 2'b00, 1'b0, "rd04_be01");
    `CHK("rd04_be01/rdata", if1.rdata, 16'hBE34)

    // Unaligned read spans Mem[5]=BE and Mem[6]=78
    txn1(1'b1, 8'h06, 16'h5678, 2'b11, 1'b0, "wr06");
    `CHK("wr06/rdata_held", if1.rdata, 16'hBE34)
    txn1(1'b0, 8'h05, 16'h0000, 2'b00, MIS, "rd05");
    `CHK("rd05/rdata", if1.rdata, MIS ? 16'hBE34 : 16'h78BE)

    // Range boundary
    txn1(1'b1, 8'h00, 16'h9999, 2'b11, 1'b0, "wr00");
    txn1(1'b1, 8'h3E, 16'hCAFE, 2'b11, 1'b0, "wr3E");
    txn1(1'b0, 8'h3E, 16'h0000, 2'b00, 1'b0, "rd3E");
    `CHK("rd3E/rdata", if1.rdata, 16'hCAFE)
    txn1(1'b0, 8'h3F, 16'h0000, 2'b00, 1'b1, "rd3F");
    `CHK("rd3F/rdata_held", if1.rdata, 16'hCAFE)
    txn1(1'b1, 8'h3F, 16'h1111, 2'b11, 1'b1, "wr3F");
    txn1(1'b1, 8'h40, 16'h2222, 2'b11, 1'b1, "wr40");
    txn1(1'b0, 8'h40, 16'h0000, 2'b00, 1'b1, "rd40");
    txn1(1'b0, 8'h3E, 16'h0000, 2'b00, 1'b0, "rd3E_again");
    `CHK("rd3E_again/rdata", if1.rdata, 16'hCAFE)
    txn1(1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, "rd00");
    `CHK("rd00/no_wrap", if1.rdata, 16'h9999)

    // be=0 is a no-op write that still completes
    txn1(1'b1, 8'h04, 16'hFFFF, 2'b00, 1'b0, "wr04_be00");
    txn1(1'b0, 8'h04, 16'h0000, 2'b00, 1'b0, "rd04_be00");
    `CHK("rd04_be00/rdata", if1.rdata, 16'hBE34)

    // Zero wait states: ready one cycle after acceptance
    if0.req = 1'b1; if0.we = 1'b1; if0.addr = 8'h10; if0.wdata = 16'h1357; if0.be = 2'b11;
    @(negedge clk);
    if0.req = 1'b0;
    `CHK("w0/ready", if0.ready, 1'b1)
    `CHK("w0/busy", if0.busy, 1'b1)
    @(negedge clk);
    `CHK("w0/ready_off", if0.ready, 1'b0)
    `CHK("w0/busy_off", if0.busy, 1'b0)

    // Three wait states: ready four cycles after acceptance
    txn3(1'b1, 8'h10, 16'h5555, 2'b11, lat);
    `CHK("w3/latency", lat, 4)
    `CHK("w3/busy_off", if3.busy, 1'b0)

    // Continuous req: one transaction per 2 (W=0) and per 5 (W=3) cycles
    if0.req = 1'b1; if0.we = 1'b0; if0.addr = 8'h10;
    if3.req = 1'b1; if3.we = 1'b0; if3.addr = 8'h10;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rb0[k] = if0.ready; bb0[k] = if0.busy;
      rb3[k] = if3.ready; bb3[k] = if3.busy;
    end
    if0.req = 1'b0; if3.req = 1'b0;
    `CHK("cont0/ready", rb0, 10'h155)
    `CHK("cont0/busy", bb0, 10'h155)
    `CHK("cont3/ready", rb3, 10'h108)
    `CHK("cont3/busy", bb3, 10'h1EF)
    `CHK("cont0/rdata", if0.rdata, 16'h1357)
    `CHK("cont3/rdata", if3.rdata, 16'h5555)
    @(negedge clk);

    // Reset during WAIT abandons the write
    if3.req = 1'b1; if3.we = 1'b1; if3.addr = 8'h10; if3.wdata = 16'hAAAA; if3.be = 2'b11;
    @(negedge clk);
    if3.req = 1'b0;
    `CHK("rstmid/busy", if3.busy, 1'b1)
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    `CHK("rstmid/ready", if3.ready, 1'b0)
    `CHK("rstmid/busy_off", if3.busy, 1'b0)
    `CHK("rstmid/err", if3.err, 1'b0)
    `CHK("rstmid/rdata", if3.rdata, 16'h0000)
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | if3.ready;
    end
    `CHK("rstmid/no_ready", seen, 1'b0)
    txn3(1'b0, 8'h10, 16'h0000, 2'b00, lat);
    `CHK("rstmid/rd_latency", lat, 4)
    `CHK("rstmid/rd10", if3.rdata, 16'h5555)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/instr_data_mem_ctrl.md
Name: instr_data_mem_ctrl

Overview:
- Parametrised, handshaked unified instruction/data memory for the multi-cycle CPU.
- Byte-addressed, little-endian storage. Multi-byte word reads and byte-enabled writes.
- Programmable wait-state latency, registered read data, and error reporting for out-of-range accesses.
- Sits between the CPU control FSM (IorD mux / MemWrite path) and the storage array.

Parameters:
- ADDR_W, 8, address width in bits
- DATA_W, 16, word width in bits; multiple of 8; BYTES = DATA_W/8
- DEPTH, 64, number of bytes of storage; must be ≤ 2^ADDR_W
- WAIT_CYCLES, 1, extra wait states between request acceptance and response; 0 is legal

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  access request, sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  byte address of lane 0
- wdata  in  DATA_W  write data; lane i = wdata[8i+7:8i]
- be  in  BYTES  byte-lane write enables
- rdata  out  DATA_W  registered read data
- ready  out  1  one-cycle response strobe
- err  out  1  error flag, valid with ready
- busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: rdata=0, ready=0, err=0, busy=0, state=IDLE, wait counter=0. Storage contents are NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, latch addr/we/wdata/be and load counter with WAIT_CYCLES.
  - If WAIT_CYCLES=0, go to RESP; otherwise go to WAIT.
- WAIT: decrement counter each cycle; go to RESP when counter reaches 1.
- RESP:
  - Perform access, drive ready=1 for exactly one cycle, return to IDLE.
  - req in this cycle is ignored; the earliest next acceptance is the following cycle.
- Latency: req accepted at edge N gives ready high during cycle N+1+WAIT_CYCLES.
- Read:
  - rdata lane i = Mem[addr+i] for i = 0..BYTES-1, loaded on the RESP edge.
  - rdata holds its value until the next read response. Writes do not alter rdata.
- Write:
  - Mem[addr+i] = lane i of wdata for each i with be[i]=1, committed on the RESP edge.
  - be = 0 is a legal no-op and still returns ready.
- Range check:
  - If addr+BYTES-1 ≥ DEPTH (computed at ADDR_W+1 bits, no wrap-around), the access is an error: err=1 with ready, no storage write, rdata unchanged.
  - Addresses never wrap.
- req while busy=1 is ignored (not queued). The master must wait for ready.
- Input changes after acceptance have no effect; latched copies are used.
- Reset mid-operation (WAIT or RESP before its edge): access abandoned, no write committed, ready not asserted, state → IDLE.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: an access with addr not a multiple of BYTES completes with ready=1, err=1, no write, and rdata unchanged. This takes priority over the range check, with identical outcome.
- Undefined: unaligned accesses are legal. Lanes map to consecutive bytes starting at addr, subject only to the range check.

Decomposition:
- Package idm_pkg:
  - state enum (IDLE, WAIT, RESP)
  - function computing BYTES from DATA_W
  - range-check helper function
- Sub-module idm_byte_array:
  - DEPTH×8 storage with BYTES write lanes (address, per-lane enable, lane data) and BYTES combinational read lanes.
  - Holds the memory array. The controller instantiates it and owns all sequencing and registers.

Test Plan:
- Defaults, WAIT_CYCLES=1: write addr=0x04, wdata=0xBEEF, be=2'b11 at edge N → ready at N+2, err=0. Then read addr=0x04 → rdata=0xBEEF, Mem[4]=0xEF, Mem[5]=0xBE.
- Byte enables: after the above, write addr=0x04, wdata=0x1234, be=2'b01 → subsequent read returns 0xBE34.
- Range: read addr=0x3F (DEPTH=64, BYTES=2) → ready with err=1, rdata unchanged. Write addr=0x40 → err=1, no storage change.
- Latency sweep, WAIT_CYCLES ∈ {0,3}:
  - ready exactly 1 and 4 cycles after acceptance respectively.
  - req held high continuously yields one transaction per 2 and 5 cycles.
  - busy is high throughout each transaction.
- Reset mid-op, WAIT_CYCLES=3: write addr=0x10, data 0xAAAA, be=2'b11; assert reset during WAIT → no ready, all outputs 0, and a later read of 0x10 returns pre-write contents.
- Misalignment: read addr=0x05. With MISALIGN_TRAP_EN → err=1. Without → err=0, rdata={Mem[6],Mem[5]}.
